// File: rtl/cmp_pkg.sv
// Shared definitions for the cmp_4bit BIST sequencer: the sequencer states,
// the sweep size, the operand width and where each flag sits in {eq,lst,grt}.
package cmp_pkg;

    localparam int OP_W      = 4;
    localparam int N_VECTORS = 256;

    // Bit positions inside a packed {eq,lst,grt} flag word
    localparam int EQ  = 2;
    localparam int LST = 1;
    localparam int GRT = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/cmp_expect.sv
// Golden model of the 4-bit unsigned magnitude comparator. Produces the
// one-hot {eq,lst,grt} word that a correct cmp_4bit must return for a/b.
module cmp_expect
    import cmp_pkg::*;
(
    input  logic [OP_W-1:0] a,
    input  logic [OP_W-1:0] b,
    output logic [2:0]      flags
);

    // Exactly one flag is set for any operand pair
    always_comb begin
        flags      = '0;
        flags[EQ]  = (a == b);
        flags[LST] = (a <  b);
        flags[GRT] = (a >  b);
    end

endmodule

// File: rtl/cmp_4bit_bist.sv
// Built-in self-test sequencer for cmp_4bit. Sweeps all 256 {a,b} pairs in
// ascending order (b is the inner loop), holds each pair for SETTLE_CYCLES
// cycles, samples the comparator flags and keeps an error count plus a record
// of the first failing vector.
//
// Run handshake: start is a level request sampled only in IDLE or DONE; the
// edge that accepts it clears the error record and raises busy. busy stays
// high until the edge that checks the last vector, where busy falls and done
// rises together. done/pass then hold until the next accepted start or rst.
// busy and done are never high at the same time.
//
// SETTLE_CYCLES legal range is 1..15 (it is compared against a 4-bit counter).
module cmp_4bit_bist
    import cmp_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            eq,
    input  logic            lst,
    input  logic            grt,
    output logic [OP_W-1:0] a,
    output logic [OP_W-1:0] b,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [8:0]      err_cnt,
    output logic [OP_W-1:0] fail_a,
    output logic [OP_W-1:0] fail_b,
    output logic [2:0]      fail_flags
);

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    state_t      state;
    logic [7:0]  n;
    logic [3:0]  settle_cnt;
    logic [2:0]  exp_flags;
    logic [2:0]  got_flags;
    logic        mismatch;
    logic [8:0]  err_next;

    // Operands come straight from the vector register, so they are registered
    // and sit at 4'hF/4'hF once the sweep has finished.
    assign a = n[7:4];
    assign b = n[3:0];

    cmp_expect u_expect (
        .a     (a),
        .b     (b),
        .flags (exp_flags)
    );

    assign got_flags = {eq, lst, grt};
    assign mismatch  = (got_flags != exp_flags);
    assign err_next  = err_cnt + {8'd0, mismatch};

    // Sequencer FSM, settle counter, vector counter and error record
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            n          <= 8'd0;
            settle_cnt <= 4'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_cnt    <= 9'd0;
            fail_a     <= '0;
            fail_b     <= '0;
            fail_flags <= 3'd0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state      <= WAIT;
                        n          <= 8'd0;
                        settle_cnt <= 4'd0;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        pass       <= 1'b0;
                        err_cnt    <= 9'd0;
                        fail_a     <= '0;
                        fail_b     <= '0;
                        fail_flags <= 3'd0;
                    end
                end
                WAIT: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        settle_cnt <= 4'd0;
                        state      <= CHECK;
                    end else begin
                        settle_cnt <= settle_cnt + 4'd1;
                    end
                end
                CHECK: begin
                    err_cnt <= err_next;
                    // Only the first failing vector is recorded
                    if (mismatch && (err_cnt == 9'd0)) begin
                        fail_a     <= a;
                        fail_b     <= b;
                        fail_flags <= got_flags;
                    end
                    if (n == 8'hFF) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_next == 9'd0);
                    end else begin
                        n     <= n + 8'd1;
                        state <= WAIT;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cmp_4bit_bist.sv
// Bench for cmp_4bit_bist: two instances (SETTLE_CYCLES 1 and 3), each driving
// a behavioural cmp_4bit whose fault mode is selectable. Run results are
// queued when start is driven and checked when done rises.
module tb_cmp_4bit_bist;

    logic clk = 1'b0;
    logic rst;
    logic start1, start3;
    int   fault_mode;

    logic [3:0] a1, b1, fa1, fb1, a3, b3, fa3, fb3;
    logic       eq1, lst1, grt1, eq3, lst3, grt3;
    logic       busy1, done1, pass1, busy3, done3, pass3;
    logic [8:0] err1, err3;
    logic [2:0] ff1, ff3;
    logic [2:0] cmp1, cmp3;

    int total = 0;
    int bad   = 0;
    logic mon_en = 1'b0;

    // packed run result: {pass, err_cnt, fail_a, fail_b, fail_flags}
    logic [20:0] exp_q[$];

    typedef struct {
        int         sel;
        int         mode;
        logic       pass;
        logic [8:0] err;
        logic [3:0] fa;
        logic [3:0] fb;
        logic [2:0] ff;
        int         cycles;
    } vec_t;

    vec_t vecs[7];

    // clock
    always #5 clk = ~clk;

    // comparator model: 0 good, 1 lst stuck 0, 2 lst/grt swapped, 3 eq stuck 0
    function automatic logic [2:0] cmp_model(input logic [3:0] x, input logic [3:0] y, input int mode);
        logic e, l, g;
        e = (x == y);
        l = (x < y);
        g = (x > y);
        case (mode)
            1: l = 1'b0;
            2: begin l = (x > y); g = (x < y); end
            3: e = 1'b0;
            default: ;
        endcase
        return {e, l, g};
    endfunction

    always_comb cmp1 = cmp_model(a1, b1, fault_mode);
    always_comb cmp3 = cmp_model(a3, b3, fault_mode);
    assign {eq1, lst1, grt1} = cmp1;
    assign {eq3, lst3, grt3} = cmp3;

    cmp_4bit_bist #(.SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1),
        .eq(eq1), .lst(lst1), .grt(grt1),
        .a(a1), .b(b1), .busy(busy1), .done(done1), .pass(pass1),
        .err_cnt(err1), .fail_a(fa1), .fail_b(fb1), .fail_flags(ff1)
    );

    cmp_4bit_bist #(.SETTLE_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst), .start(start3),
        .eq(eq3), .lst(lst3), .grt(grt3),
        .a(a3), .b(b3), .busy(busy3), .done(done3), .pass(pass3),
        .err_cnt(err3), .fail_a(fa3), .fail_b(fb3), .fail_flags(ff3)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // busy and done must never be high together
    always @(negedge clk) begin
        if (mon_en) begin
            total++;
            if ((busy1 && done1) || (busy3 && done3)) begin
                bad++;
                $display("FAIL busy_done_overlap: busy1=%0b done1=%0b busy3=%0b done3=%0b",
                         busy1, done1, busy3, done3);
            end
        end
    end

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_dut1"}, {1'b0, a1, b1, busy1, done1, pass1, err1, fa1, fb1, ff1}, 32'd0);
        chk({tag, "_dut3"}, {1'b0, a3, b3, busy3, done3, pass3, err3, fa3, fb3, ff3}, 32'd0);
    endtask

    // One full run on the chosen instance; optional start pulses mid-run
    task automatic run_one(input vec_t v, input bit pulse_mid, input string name);
        int cyc;
        bit seen;
        logic [20:0] got, exp;
        fault_mode = v.mode;
        @(posedge clk); #1;
        exp_q.push_back({v.pass, v.err, v.fa, v.fb, v.ff});
        if (v.sel == 1) start1 = 1'b1; else start3 = 1'b1;
        @(posedge clk); #1;                       // edge E0 samples start
        start1 = 1'b0;
        start3 = 1'b0;
        if (v.sel == 1) chk({name, "_start_state"}, {busy1, done1, a1, b1}, {2'b10, 8'h00});
        else            chk({name, "_start_state"}, {busy3, done3, a3, b3}, {2'b10, 8'h00});
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 5000) begin
            @(posedge clk); #1;
            cyc++;
            if (pulse_mid && (cyc == 50 || cyc == 300)) begin
                if (v.sel == 1) start1 = 1'b1; else start3 = 1'b1;
            end else begin
                start1 = 1'b0;
                start3 = 1'b0;
            end
            seen = (v.sel == 1) ? done1 : done3;
        end
        start1 = 1'b0;
        start3 = 1'b0;
        exp = exp_q.pop_front();
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: done not seen after %0d cycles, required %0d", name, cyc, v.cycles);
        end else begin
            if (v.sel == 1) got = {pass1, err1, fa1, fb1, ff1};
            else            got = {pass3, err3, fa3, fb3, ff3};
            chk({name, "_cycles"}, cyc, v.cycles);
            chk({name, "_err_cnt"}, got[19:11], exp[19:11]);
            chk({name, "_record"}, {got[20], got[10:0]}, {exp[20], exp[10:0]});
            if (v.sel == 1) chk({name, "_done_ab"}, {busy1, a1, b1}, {1'b0, 8'hFF});
            else            chk({name, "_done_ab"}, {busy3, a3, b3}, {1'b0, 8'hFF});
        end
    endtask

    initial begin
        vec_t v;
        vecs[0] = '{1, 0, 1'b1, 9'd0,   4'd0, 4'd0, 3'b000, 512};
        vecs[1] = '{1, 1, 1'b0, 9'd120, 4'd0, 4'd1, 3'b000, 512};
        vecs[2] = '{1, 2, 1'b0, 9'd240, 4'd0, 4'd1, 3'b001, 512};
        vecs[3] = '{1, 3, 1'b0, 9'd16,  4'd0, 4'd0, 3'b000, 512};
        vecs[4] = '{3, 3, 1'b0, 9'd16,  4'd0, 4'd0, 3'b000, 1024};
        vecs[5] = '{3, 0, 1'b1, 9'd0,   4'd0, 4'd0, 3'b000, 1024};
        vecs[6] = '{1, 1, 1'b0, 9'd120, 4'd0, 4'd1, 3'b000, 512};

        rst        = 1'b1;
        start1     = 1'b0;
        start3     = 1'b0;
        fault_mode = 0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("reset");
        rst    = 1'b0;
        mon_en = 1'b1;

        // table-driven runs; every run after the first on an instance starts from DONE
        for (int i = 0; i < 7; i++) begin
            run_one(vecs[i], 1'b0, $sformatf("vec%0d", i));
        end

        // start pulses while the run is in progress must be ignored
        run_one(vecs[2], 1'b1, "ignore_start");

        // reset in the middle of a run
        fault_mode = 1;
        @(posedge clk); #1;
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        chk("midrun_busy", busy1, 1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk_reset_vals("midrun_rst");

        // reset has priority over start
        start1 = 1'b1;
        start3 = 1'b1;
        @(posedge clk); #1;
        chk_reset_vals("rst_vs_start");
        rst    = 1'b0;
        start1 = 1'b0;
        start3 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("idle_after_rst", {busy1, done1, busy3, done3}, 4'b0000);

        // a clean run from IDLE after the abort
        v = vecs[0];
        run_one(v, 1'b0, "post_rst");

        mon_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
